// File: rtl/reg_write_arbiter_pkg.sv
// Shared writeback definitions: register file geometry and requester identifiers.
package reg_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned REG_DATA_W = 8;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    // Requester IDs; also used as the grant select and the age pointer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/reg_write_arbiter_wb_slot.sv
// One-entry writeback holding slot: full flag, captured addr/data and the READY equation.
module wb_slot
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              accept,
    input  logic              clear,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ready,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Slot may take a new entry when empty or when its current entry leaves this edge.
    always_comb begin
        ready = !RESET && (!full_q || clear);
    end

    // Capture on accept (a same-edge refill wins over the clear); otherwise drop on grant.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            addr_q <= req_addr;
            data_q <= req_data;
        end else if (clear) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester writeback arbiter for the register file's single write port.
// Oldest-first issue, one write per cycle, registered write outputs and a pending scoreboard.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned NREG   = NUM_REGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic [NREG-1:0]   PENDING
);

    logic              full0, full1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              acc0, acc1;
    logic              clear0, clear1;
    logic              gnt_valid;
    req_id_e           gnt_sel;
    logic              stay0, stay1;

    req_id_e           older_q;
    logic              write_q;
    logic [ADDR_W-1:0] inaddress_q;
    logic [DATA_W-1:0] in_q;

    wb_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot0 (
        .CLK      (CLK),
        .RESET    (RESET),
        .accept   (acc0),
        .clear    (clear0),
        .req_addr (REQ0_ADDR),
        .req_data (REQ0_DATA),
        .ready    (REQ0_READY),
        .full     (full0),
        .addr     (addr0),
        .data     (data0)
    );

    wb_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .accept   (acc1),
        .clear    (clear1),
        .req_addr (REQ1_ADDR),
        .req_data (REQ1_DATA),
        .ready    (REQ1_READY),
        .full     (full1),
        .addr     (addr1),
        .data     (data1)
    );

    assign acc0 = REQ0_VALID && REQ0_READY;
    assign acc1 = REQ1_VALID && REQ1_READY;

    // Grant from registered state only: the sole full slot, else the older one.
    always_comb begin
        gnt_valid = full0 || full1;
        if (full0 && full1) begin
            gnt_sel = older_q;
        end else if (full1) begin
            gnt_sel = REQ_MEM;
        end else begin
            gnt_sel = REQ_ALU;
        end
        clear0 = gnt_valid && (gnt_sel == REQ_ALU);
        clear1 = gnt_valid && (gnt_sel == REQ_MEM);
        stay0  = full0 && !clear0;
        stay1  = full1 && !clear1;
    end

    // Issue the granted entry and track which occupied slot arrived first.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_q     <= 1'b0;
            inaddress_q <= '0;
            in_q        <= '0;
            older_q     <= REQ_ALU;
        end else begin
            write_q <= gnt_valid;
            if (gnt_valid) begin
                inaddress_q <= (gnt_sel == REQ_MEM) ? addr1 : addr0;
                in_q        <= (gnt_sel == REQ_MEM) ? data1 : data0;
            end
            if (acc0 && acc1) begin
                older_q <= REQ_ALU;
            end else if (acc0 && stay1) begin
                older_q <= REQ_MEM;
            end else if (acc1 && stay0) begin
                older_q <= REQ_ALU;
            end
        end
    end

    // Scoreboard of destinations held in a slot or currently on the write port.
    always_comb begin
        PENDING = '0;
        if (full0) begin
            PENDING[addr0] = 1'b1;
        end
        if (full1) begin
            PENDING[addr1] = 1'b1;
        end
        if (write_q) begin
            PENDING[inaddress_q] = 1'b1;
        end
    end

    assign WRITE     = write_q;
    assign INADDRESS = inaddress_q;
    assign IN        = in_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter with a behavioural register file.
module tb_reg_write_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid;
    logic [2:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       write;
    logic [2:0] inaddress;
    logic [7:0] in_data;
    logic [7:0] pending;

    logic [7:0]  rf [8];
    int          wr_count;
    logic [10:0] wr_log [$];
    int          n_checks;
    int          n_errors;

    reg_write_arbiter dut (
        .CLK        (clk),
        .RESET      (reset),
        .REQ0_VALID (req0_valid),
        .REQ0_ADDR  (req0_addr),
        .REQ0_DATA  (req0_data),
        .REQ0_READY (req0_ready),
        .REQ1_VALID (req1_valid),
        .REQ1_ADDR  (req1_addr),
        .REQ1_DATA  (req1_data),
        .REQ1_READY (req1_ready),
        .WRITE      (write),
        .INADDRESS  (inaddress),
        .IN         (in_data),
        .PENDING    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file sharing the system reset; commits on the edge that ends a WRITE cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) rf[r] <= 8'h00;
        end else if (write) begin
            rf[inaddress] <= in_data;
        end
    end

    // Count and log every committed write.
    always @(posedge clk) begin
        if (!reset && write) begin
            wr_count = wr_count + 1;
            wr_log.push_back({inaddress, in_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          base;
        int          i0;
        int          i1;
        int          c;
        logic        r0;
        logic        r1;
        logic        v0;
        logic        v1;
        logic [10:0] exp_log [8];

        n_checks   = 0;
        n_errors   = 0;
        wr_count   = 0;
        reset      = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;

        // Reset state
        tick();
        check("rst_write", write, 1'b0);
        check("rst_inaddress", inaddress, 3'd0);
        check("rst_in", in_data, 8'h00);
        check("rst_pending", pending, 8'h00);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rel_ready0", req0_ready, 1'b1);
        check("rel_ready1", req1_ready, 1'b1);

        // Single uncontended request
        req0_valid = 1'b1;
        req0_addr  = 3'd3;
        req0_data  = 8'hA5;
        tick();
        req0_valid = 1'b0;
        check("single_pend_n", pending, 8'h08);
        check("single_write_n", write, 1'b0);
        tick();
        check("single_write", write, 1'b1);
        check("single_addr", inaddress, 3'd3);
        check("single_data", in_data, 8'hA5);
        check("single_pend_n1", pending, 8'h08);
        tick();
        check("single_write_off", write, 1'b0);
        check("single_pend_n2", pending, 8'h00);
        check("single_rf3", rf[3], 8'hA5);

        // Same-edge accept to one register: slot0 first
        req0_valid = 1'b1;
        req0_addr  = 3'd2;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_addr  = 3'd2;
        req1_data  = 8'h22;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("same_pend", pending, 8'h04);
        tick();
        check("same_w1", write, 1'b1);
        check("same_d1", in_data, 8'h11);
        tick();
        check("same_w2", write, 1'b1);
        check("same_d2", in_data, 8'h22);
        check("same_rf_mid", rf[2], 8'h11);
        tick();
        check("same_w3", write, 1'b0);
        check("same_rf2", rf[2], 8'h22);

        // Arrival order: slot1 first, then slot0
        req1_valid = 1'b1;
        req1_addr  = 3'd5;
        req1_data  = 8'h7E;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 3'd5;
        req0_data  = 8'h01;
        check("order_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        check("order_d1", in_data, 8'h7E);
        tick();
        check("order_d2", in_data, 8'h01);
        tick();
        check("order_rf5", rf[5], 8'h01);

        // REQ0 streams addresses 0..7
        base = wr_count;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 3'(i);
            req0_data  = 8'(i + 8'h10);
            check("stream0_ready", req0_ready, 1'b1);
            tick();
            if (i >= 1) check("stream0_write", write, 1'b1);
        end
        req0_valid = 1'b0;
        tick();
        check("stream0_last_w", write, 1'b1);
        check("stream0_last_a", inaddress, 3'd7);
        check("stream0_last_d", in_data, 8'h17);
        tick();
        check("stream0_idle", write, 1'b0);
        check("stream0_count", wr_count - base, 8);
        for (int r = 0; r < 8; r++) check("stream0_rf", rf[r], 8'(r + 8'h10));

        // Both requesters stream four requests each
        base = wr_count;
        wr_log.delete();
        i0 = 0;
        i1 = 0;
        c  = 0;
        while ((i0 < 4 || i1 < 4) && c < 40) begin
            v0 = (i0 < 4);
            v1 = (i1 < 4);
            req0_valid = v0;
            req0_addr  = 3'(i0);
            req0_data  = 8'(8'h40 + i0);
            req1_valid = v1;
            req1_addr  = 3'(4 + i1);
            req1_data  = 8'(8'h80 + i1);
            r0 = req0_ready;
            r1 = req1_ready;
            if (c >= 1 && c <= 6) begin
                check("both_ready0", r0, (c % 2) == 1);
                check("both_ready1", r1, (c % 2) == 0);
            end
            tick();
            if (v0 && r0) i0++;
            if (v1 && r1) i1++;
            c++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("both_bound", c < 40, 1'b1);
        c = 0;
        while ((pending != 8'h00 || write) && c < 10) begin
            tick();
            c++;
        end
        check("both_drain", c < 10, 1'b1);
        check("both_pending", pending, 8'h00);
        check("both_count", wr_count - base, 8);
        for (int k = 0; k < 4; k++) begin
            exp_log[2*k]   = {3'(k), 8'(8'h40 + k)};
            exp_log[2*k+1] = {3'(4 + k), 8'(8'h80 + k)};
        end
        check("both_log_len", wr_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < wr_log.size()) check("both_order", wr_log[k], exp_log[k]);
        end

        // Reset mid-cycle with both slots occupied and a write on the port
        req0_valid = 1'b1;
        req0_addr  = 3'd6;
        req0_data  = 8'hC6;
        req1_valid = 1'b1;
        req1_addr  = 3'd7;
        req1_data  = 8'hC7;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("mid_pend_full", pending, 8'hC0);
        tick();
        check("mid_write_pre", write, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_write", write, 1'b0);
        check("mid_pending", pending, 8'h00);
        check("mid_ready0", req0_ready, 1'b0);
        check("mid_ready1", req1_ready, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("post_ready0", req0_ready, 1'b1);
        check("post_ready1", req1_ready, 1'b1);
        base = wr_count;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_no_write", write, 1'b0);
        end
        check("post_count", wr_count - base, 0);
        check("post_rf6", rf[6], 8'h00);
        check("post_rf7", rf[7], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
